mult_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational W×W unsigned array multiplier among NREQ requesters. Each requester presents operands on a valid/ready handshake. The block registers the winner's operands onto the multiplier inputs, captures the 2W-bit product one cycle later, and returns it on a per-requester response handshake. It sits between the requesting datapath clients and a single multiplier instance, which is external and attached through the mul_* ports.

---
 rtl/mult_share_arb.sv | 104 ++++++++++
 tb/tb_mult_share_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// Round-robin sequencer that time-shares one external W x W multiplier among NREQ
// requesters: grant in IDLE, let the product settle in ISSUE, hold it in RESP.
//
// state | meaning
// IDLE  | scanning req_valid from ptr; the first valid requester is granted
// ISSUE | operands sit on mul_x/mul_y; the product is captured at the end of the cycle
// RESP  | rsp_valid[owner] held with rsp_data until rsp_ready[owner]
module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic [2*W-1:0]    mul_o,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_data,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic              busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;
    logic          win_vld;
    logic          accept;

    // Scan starts at ptr and wraps modulo NREQ, which need not be a power of two.
    always_comb begin
        logic [PW:0] idx;
        idx     = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!win_vld && req_valid[idx[PW-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[PW-1:0];
            end
        end
    end

    assign ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign accept  = (state == IDLE) && win_vld;

    // Gated by rst so the grant drops immediately when reset asserts.
    assign req_ready = (accept && !rst) ? (NREQ'(1) << win) : '0;
    assign rsp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            mul_x    <= '0;
            mul_y    <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                mul_x <= req_x[int'(win)*W +: W];
                mul_y <= req_y[int'(win)*W +: W];
                owner <= win;
                ptr   <= ptr_nxt;
            end
            // Multiplier inputs changed a full cycle earlier, so mul_o has settled here.
            if (state == ISSUE) begin
                rsp_data <= mul_o;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: a cycle model predicts grants and
// handshakes, expected products queue at acceptance and are checked in RESP.
module tb_mult_share_arb;
    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic [2*W-1:0]    mul_o;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_data;
    logic [NREQ-1:0]   rsp_ready;
    logic              busy;

    mult_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_o     (mul_o),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // External combinational multiplier.
    assign mul_o = (2*W)'(mul_x) * (2*W)'(mul_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int prod;
    } exp_t;

    exp_t            sb[$];
    int              grant_log[$];
    int              acc_cyc[$];
    int              rsp_log[$];
    int              rsp_cyc[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              m_state = 0;
    int              m_ptr = 0;
    int              m_owner = 0;
    int              m_x = 0;
    int              m_y = 0;
    logic [NREQ-1:0] last_acc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        int g;
        int idx;
        int x;
        int y;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
            chk("rst_mul_x", 32'(mul_x), 32'd0);
            chk("rst_mul_y", 32'(mul_y), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            m_state  = 0;
            m_ptr    = 0;
            m_owner  = 0;
            last_acc = '0;
            sb.delete();
        end else begin
            last_acc = '0;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && ((32'(req_valid) >> idx) & 32'd1) != 0) g = idx;
            end
            chk("req_ready", 32'(req_ready), (m_state == 0 && g >= 0) ? (32'd1 << g) : 32'd0);
            chk("rsp_valid", 32'(rsp_valid), (m_state == 2) ? (32'd1 << m_owner) : 32'd0);
            chk("busy", 32'(busy), (m_state != 0) ? 32'd1 : 32'd0);
            case (m_state)
                0: if (g >= 0) begin
                    x = (int'(req_x) >> (g*W)) % (1 << W);
                    y = (int'(req_y) >> (g*W)) % (1 << W);
                    sb.push_back('{g, x*y});
                    grant_log.push_back(g);
                    acc_cyc.push_back(cyc);
                    last_acc = NREQ'(1) << g;
                    m_x     = x;
                    m_y     = y;
                    m_owner = g;
                    m_ptr   = (g + 1) % NREQ;
                    m_state = 1;
                end
                1: begin
                    chk("mul_x", 32'(mul_x), m_x);
                    chk("mul_y", 32'(mul_y), m_y);
                    m_state = 2;
                end
                default: begin
                    chk("sb_depth", sb.size(), 32'd1);
                    if (sb.size() > 0) chk("rsp_data", 32'(rsp_data), sb[0].prod);
                    if (((32'(rsp_ready) >> m_owner) & 32'd1) != 0) begin
                        rsp_log.push_back(int'(rsp_data));
                        rsp_cyc.push_back(cyc);
                        if (sb.size() > 0) void'(sb.pop_front());
                        m_state = 0;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        acc_cyc.delete();
        rsp_log.delete();
        rsp_cyc.delete();
    endtask

    // Drops each request the cycle after it is accepted; bounded.
    task automatic drain_requests();
        for (int c = 0; c < 100 && req_valid != '0; c++) begin
            tick();
            req_valid = req_valid & ~last_acc;
        end
        chk("drain_wait", 32'(req_valid), 32'd0);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && (sb.size() != 0 || m_state != 0); c++) tick();
        chk("idle_wait", sb.size(), 32'd0);
    endtask

    task automatic set_ops(input int i, input int x, input int y);
        req_x[i*W +: W] = W'(x);
        req_y[i*W +: W] = W'(y);
    endtask

    task automatic do_op(input int i, input int x, input int y);
        set_ops(i, x, y);
        req_valid[i] = 1'b1;
        drain_requests();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time %0t reached, limit 200000", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int c0;
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '1;
        tick();
        tick();
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // single requester, grant in the first cycle after reset, II of 3
        clear_logs();
        rst = 1'b0;
        c0  = cyc;
        set_ops(0, 15, 15);
        req_valid[0] = 1'b1;
        for (int c = 0; c < 30 && grant_log.size() < 2; c++) tick();
        req_valid = '0;
        wait_idle();
        chk("t1_grant", qat(grant_log, 0), 32'd0);
        chk("t1_first_cycle", qat(acc_cyc, 0), c0);
        chk("t1_product", qat(rsp_log, 0), 32'd225);
        chk("t1_latency", qat(rsp_cyc, 0) - qat(acc_cyc, 0), 32'd2);
        chk("t1_interval", qat(acc_cyc, 1) - qat(acc_cyc, 0), 32'd3);

        // exhaustive sweep on requester 2
        clear_logs();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                do_op(2, x, y);
        wait_idle();
        chk("sweep_count", rsp_log.size(), 32'd256);
        chk("sweep_9x13", qat(rsp_log, 9*16 + 13), 32'd117);
        chk("sweep_0x7", qat(rsp_log, 7), 32'd0);
        for (int i = 0; i < 256; i++) chk("sweep_log", qat(rsp_log, i), (i / 16) * (i % 16));

        // backpressure on requester 1, with requester 0 waiting and its rsp_ready pulsed
        rsp_ready = '0;
        do_op(1, 7, 6);
        tick();
        set_ops(0, 1, 1);
        req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rsp_ready = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd2);
            chk("bp_rsp_data", 32'(rsp_data), 32'd42);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        chk("bp_hs_valid", 32'(rsp_valid), 32'd2);
        tick();
        chk("bp_after_valid", 32'(rsp_valid), 32'd0);
        chk("bp_after_busy", 32'(busy), 32'd0);
        rsp_ready = '1;
        drain_requests();
        wait_idle();

        // pointer wrap: after requester 2, ptr = 3
        do_op(2, 1, 2);
        wait_idle();
        clear_logs();
        set_ops(0, 3, 3);
        set_ops(3, 2, 2);
        req_valid = 4'b1001;
        drain_requests();
        wait_idle();
        chk("wrap_first", qat(grant_log, 0), 32'd3);
        chk("wrap_second", qat(grant_log, 1), 32'd0);

        // reset during ISSUE of 5*5
        do_op(1, 5, 5);
        set_ops(3, 2, 3);
        req_valid[3] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mul_x", 32'(mul_x), 32'd0);
        chk("mid_rst_mul_y", 32'(mul_y), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        tick();
        clear_logs();
        rst = 1'b0;
        c0  = cyc;
        @(negedge clk);
        chk("post_rst_grant3", 32'(req_ready), 32'd8);
        drain_requests();
        wait_idle();
        chk("post_rst_cycle", qat(acc_cyc, 0), c0);
        chk("post_rst_rsp_count", rsp_log.size(), 32'd1);
        chk("post_rst_product", qat(rsp_log, 0), 32'd6);
        set_ops(0, 4, 4);
        req_valid = 4'b1001;
        drain_requests();
        wait_idle();
        chk("post_rst_next0", qat(grant_log, 1), 32'd0);
        chk("post_rst_next3", qat(grant_log, 2), 32'd3);

        // full load from reset, x = i+1, y = 3
        rst       = 1'b1;
        req_x     = {4'd4, 4'd3, 4'd2, 4'd1};
        req_y     = {4'd3, 4'd3, 4'd3, 4'd3};
        req_valid = '1;
        tick();
        tick();
        clear_logs();
        rst = 1'b0;
        for (int c = 0; c < 60 && grant_log.size() < 8; c++) tick();
        req_valid = '0;
        wait_idle();
        for (int i = 0; i < 8; i++) chk("rr_order", qat(grant_log, i), i % NREQ);
        for (int i = 0; i < 4; i++) chk("rr_product", qat(rsp_log, i), 3 * (i + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
